// File: rtl/hpdcache_victim_ctrl_if.sv
// Bundle of the handshake and data buses around the victim controller.
// Signal suffixes are from the controller's point of view.
interface hpdcache_victim_ctrl_if #(
  parameter int SETS = 64,
  parameter int WAYS = 4
);
  localparam int SET_W = $clog2(SETS);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [SET_W-1:0] req_set_i;

  logic             dir_rd_o;
  logic [SET_W-1:0] dir_rd_set_o;
  logic [WAYS-1:0]  dir_valid_i;
  logic [WAYS-1:0]  dir_wb_i;
  logic [WAYS-1:0]  dir_dirty_i;

  logic [WAYS-1:0]  sel_dir_valid_o;
  logic [WAYS-1:0]  sel_dir_wb_o;
  logic [WAYS-1:0]  sel_dir_dirty_o;
  logic [WAYS-1:0]  sel_victim_way_i;

  logic             repl_o;
  logic [SET_W-1:0] repl_set_o;
  logic [WAYS-1:0]  repl_way_o;

  logic             evict_valid_o;
  logic             evict_ready_i;
  logic [SET_W-1:0] evict_set_o;
  logic [WAYS-1:0]  evict_way_o;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WAYS-1:0]  rsp_way_o;
  logic             rsp_err_o;

  logic             busy_o;

  modport master (
    input  req_valid_i, req_set_i,
    input  dir_valid_i, dir_wb_i, dir_dirty_i,
    input  sel_victim_way_i, evict_ready_i, rsp_ready_i,
    output req_ready_o, dir_rd_o, dir_rd_set_o,
    output sel_dir_valid_o, sel_dir_wb_o, sel_dir_dirty_o,
    output repl_o, repl_set_o, repl_way_o,
    output evict_valid_o, evict_set_o, evict_way_o,
    output rsp_valid_o, rsp_way_o, rsp_err_o, busy_o
  );

  modport slave (
    output req_valid_i, req_set_i,
    output dir_valid_i, dir_wb_i, dir_dirty_i,
    output sel_victim_way_i, evict_ready_i, rsp_ready_i,
    input  req_ready_o, dir_rd_o, dir_rd_set_o,
    input  sel_dir_valid_o, sel_dir_wb_o, sel_dir_dirty_o,
    input  repl_o, repl_set_o, repl_way_o,
    input  evict_valid_o, evict_set_o, evict_way_o,
    input  rsp_valid_o, rsp_way_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/hpdcache_victim_ctrl.sv
// Refill-side victim controller: reads a set's directory, lets the PLRU pick a
// victim, writes back a dirty victim, commits the replacement and answers the miss handler.
module hpdcache_victim_ctrl #(
  parameter int SETS      = 64,
  parameter int WAYS      = 4,
  parameter int RETRY_MAX = 3
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_victim_ctrl_if.master bus
);
  localparam int SET_W   = $clog2(SETS);
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_SEL,
    S_EVICT,
    S_COMMIT,
    S_RSP
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [WAYS-1:0]    way_q, way_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               err_q, err_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               victim_dirty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign retry_inc    = retry_q + RETRY_W'(1);
  // Only a victim that is valid, write-back and dirty needs to leave the cache first.
  assign victim_dirty = |(bus.sel_victim_way_i & bus.dir_valid_i & bus.dir_wb_i & bus.dir_dirty_i);

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    retry_d = retry_q;
    err_d   = err_q;

    bus.req_ready_o     = 1'b0;
    bus.dir_rd_o        = 1'b0;
    bus.dir_rd_set_o    = '0;
    bus.sel_dir_valid_o = '0;
    bus.sel_dir_wb_o    = '0;
    bus.sel_dir_dirty_o = '0;
    bus.repl_o          = 1'b0;
    bus.repl_set_o      = '0;
    bus.repl_way_o      = '0;
    bus.evict_valid_o   = 1'b0;
    bus.evict_set_o     = '0;
    bus.evict_way_o     = '0;
    bus.rsp_valid_o     = 1'b0;
    bus.rsp_way_o       = '0;
    bus.rsp_err_o       = 1'b0;
    bus.busy_o          = (state_q != S_IDLE);

    // The PLRU indexes its tree with this set while the selection is in progress.
    if (state_q != S_IDLE) begin
      bus.repl_set_o = set_q;
    end

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready_o = ~rst_i;
        if (bus.req_valid_i && !rst_i) begin
          set_d   = bus.req_set_i;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        bus.dir_rd_o     = 1'b1;
        bus.dir_rd_set_o = set_q;
        state_d          = S_SEL;
      end
      S_SEL: begin
        bus.sel_dir_valid_o = bus.dir_valid_i;
        bus.sel_dir_wb_o    = bus.dir_wb_i;
        bus.sel_dir_dirty_o = bus.dir_dirty_i;
        way_d               = bus.sel_victim_way_i;
        if (bus.sel_victim_way_i == '0) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_W'(RETRY_MAX)) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = S_RD;
          end
        end else if (victim_dirty) begin
          state_d = S_EVICT;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_EVICT: begin
        bus.evict_valid_o = 1'b1;
        bus.evict_set_o   = set_q;
        bus.evict_way_o   = way_q;
        if (bus.evict_ready_i) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        bus.repl_o     = 1'b1;
        bus.repl_way_o = way_q;
        state_d        = S_RSP;
      end
      S_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_way_o   = err_q ? '0 : way_q;
        bus.rsp_err_o   = err_q;
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule
